// File: rtl/swi_debounce.sv
// Slide-switch conditioner: per-bit synchronizer, debounce FSM and registered rise/fall/changed pulses.
// Build option SWI_TOGGLE_EN adds a per-bit toggle register driven by accepted rising edges.
module swi_debounce #(
  parameter int NBITS         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_db,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             changed,
  output logic [NBITS-1:0] toggle_q
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  logic [NBITS-1:0] sync_q [SYNC_STAGES];
  logic [NBITS-1:0] sync_d [SYNC_STAGES];
  logic [NBITS-1:0] s;

  state_t           state_q [NBITS];
  state_t           state_d [NBITS];
  logic [CNT_W-1:0] cnt_q   [NBITS];
  logic [CNT_W-1:0] cnt_d   [NBITS];

  logic [NBITS-1:0] swi_db_q, swi_db_d;
  logic [NBITS-1:0] rise_q, rise_d;
  logic [NBITS-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  always_comb begin
    sync_d[0] = swi_raw;
    for (int j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    swi_db_d = swi_db_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NBITS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (s[i] != swi_db_q[i]) begin
            if (STABLE_CYCLES == 1) begin
              swi_db_d[i] = s[i];
              rise_d[i]   = s[i];
              fall_d[i]   = ~s[i];
            end else begin
              cnt_d[i]   = CNT_ONE;
              state_d[i] = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (s[i] == swi_db_q[i]) begin
            // Level fell back before it was stable long enough: drop it silently.
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            swi_db_d[i] = s[i];
            rise_d[i]   = s[i];
            fall_d[i]   = ~s[i];
            cnt_d[i]    = '0;
            state_d[i]  = ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
    changed_d = |(rise_d | fall_d);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the sync chain depends on this).
  always_ff @(posedge clk_2) begin
    if (reset) begin
      // NOTE: the sync chain and per-bit arrays are plain flops, not RAM, so they are reset
      // element by element; a pending count must not survive reset.
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
      for (int i = 0; i < NBITS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      swi_db_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_d[j];
      end
      for (int i = 0; i < NBITS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      swi_db_q  <= swi_db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

`ifdef SWI_TOGGLE_EN
  logic [NBITS-1:0] toggle_d;

  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end
`else
  assign toggle_q = '0;
`endif

  assign swi_db  = swi_db_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

  a_pulse_exclusive: assert property (@(posedge clk_2) disable iff (reset)
    (rise_q & fall_q) == '0);

  a_changed_consistent: assert property (@(posedge clk_2) disable iff (reset)
    changed_q == |(rise_q | fall_q));

endmodule
